lc3_mem_interface: RTL and testbench
====================================

# lc3_mem_interface

Memory-interface stage of the LC-3 datapath, sitting directly downstream of the LC-3 control unit. It holds the MAR and MDR registers and executes the control unit's `ldMAR`, `ldMDR`, `selMDR`, `memWE` and `enaMDR` commands against an external handshaked memory. It returns a one-cycle `mem_ready` so the control FSM can leave its memory-wait states. Instruction fetches and data loads/stores pass through this block, and the fetched word reaches `ldIR` via the MDR.

## Interface
- `TIMEOUT_CYC`, default 64: maximum `REQ` cycles without `mem_ack` before an access is force-completed.
- `clk  input  1`: sole clock; all state updates on rising edge.
- `reset  input  1`: synchronous, active-high.
- `bus_in  input  16`: datapath bus value.
- `ldMAR  input  1`: load MAR from `bus_in`.
- `ldMDR  input  1`: load MDR; source chosen by `selMDR`.
- `selMDR  input  1`: 0 = bus load; 1 = memory read.
- `memWE  input  1`: memory write of MDR to address MAR.
- `enaMDR  input  1`: gate MDR onto `mdr_bus`.
- `mdr_bus  output  16`: `enaMDR ? MDR : 16'h0000` (combinational, OR-bus style).
- `mar_q  output  16`: current MAR.
- `mem_ready  output  1`: one-cycle pulse; access complete.
- `mem_err  output  1`: sticky timeout flag.
- `mem_addr  output  16`: always equals MAR.
- `mem_wdata  output  16`: always equals MDR.
- `mem_req  output  1`: request, held until ack or timeout.
- `mem_we  output  1`: 1 = write, valid while `mem_req`.
- `mem_rdata  input  16`: read data, valid with `mem_ack`.
- `mem_ack  input  1`: memory completion, sampled only in `REQ`.

## Operation
- **FSM states:** `IDLE`, `REQ`, `DONE`.
- **`IDLE`:**
  - `ldMAR`=1: MAR <= `bus_in`. No access starts in the same cycle, even if one is requested. A request still held next cycle starts then.
  - Else if `memWE`=1: latch write, `mem_we`<=1, go to `REQ`.
  - Else if `ldMDR`=1 and `selMDR`=1: latch read, `mem_we`<=0, go to `REQ`.
  - Else if `ldMDR`=1 and `selMDR`=0: MDR <= `bus_in`.
  - `memWE` beats read when both are requested.
  - Both `ldMAR` and an MDR bus-load can take effect in the same `IDLE` cycle.
- **`REQ`:**
  - `mem_req`=1; timeout counter increments each cycle.
  - `mem_ack`=1: on a read, MDR <= `mem_rdata`; go to `DONE`.
  - Counter reaches `TIMEOUT_CYC` without ack: `mem_err` <= 1; on a read, MDR <= 16'h0000; go to `DONE`.
  - `ldMAR`, `ldMDR` and `memWE` are ignored. MAR and MDR stay stable for the whole access.
- **`DONE`:**
  - `mem_ready`=1, `mem_req`=0; clear counter; go to `IDLE`.
  - Command inputs are ignored in this cycle. The control unit drops its request after seeing `mem_ready`.
- Counter width is `$clog2(TIMEOUT_CYC+1)`; it never wraps.
- `mem_err` clears only on reset.

## Timing
- **Reset values:** MAR=0, MDR=0, state `IDLE`, counter=0, `mem_req`=0, `mem_we`=0, `mem_ready`=0, `mem_err`=0, `mdr_bus`=0 (for `enaMDR`=0).
- Reset asserted mid-access aborts it: `mem_req` is 0 the cycle after the reset edge, and no `mem_ready` is issued.
- **Access latency:**
  - Start edge E0 puts the FSM in `REQ`.
  - An ack seen k cycles after E0 (k ≥ 1) gives `DONE` at E0+k, with `mem_ready` high for cycle E0+k.
  - Zero-wait memory (ack on the first `REQ` cycle): `mem_ready` 2 cycles after the command is first asserted.
- Timeout: `mem_ready` 1+`TIMEOUT_CYC` cycles after E0.
- A read result is visible in MDR during the `mem_ready` cycle, so the control unit may assert `ldIR` in that cycle.
- Back-to-back accesses: at most one per 3 cycles (`IDLE`, `REQ`, `DONE`).

## Test plan
- **Fetch:** `bus_in`=16'h3000 with `ldMAR`; then `ldMDR`+`selMDR` held. Memory acks in the first `REQ` cycle with 16'h1261. Expect `mem_addr`=16'h3000, `mem_we`=0, and `mem_ready` one pulse with MDR=16'h1261. `enaMDR` then gives `mdr_bus`=16'h1261.
- **Store:** MAR=16'h4000; MDR bus-load 16'hBEEF; `memWE`. Memory acks after 3 wait cycles. Expect `mem_req` high 4 cycles, `mem_we`=1, `mem_wdata`=16'hBEEF, `mem_ready` 4 cycles after the start edge, MDR unchanged.
- **Timeout (`TIMEOUT_CYC`=4):** read with no ack. Expect `mem_ready` 5 cycles after start, MDR=16'h0000, `mem_err`=1, and `mem_err` still 1 after a later good access.
- **Collisions:**
  - `ldMAR`(16'h5000) with a read request in `IDLE`: MAR loads first, access starts next cycle at address 16'h5000.
  - `memWE` with a read request: write performed.
  - `ldMAR`(16'h6000) during `REQ`: MAR stays 16'h5000.
- **Reset mid-access:** reset asserted on the 2nd `REQ` cycle. Next cycle: `mem_req`=0, MAR=0, MDR=0, no `mem_ready`. A fresh read then completes normally.

Source files
------------

// File: rtl/lc3_mem_interface.sv
// LC-3 memory-interface stage: MAR/MDR registers plus a handshaked access FSM
// (IDLE -> REQ -> DONE) with a bounded wait and a sticky timeout flag.
module lc3_mem_interface #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_bus_in,
    input  logic        i_ldMAR,
    input  logic        i_ldMDR,
    input  logic        i_selMDR,
    input  logic        i_memWE,
    input  logic        i_enaMDR,
    output logic [15:0] o_mdr_bus,
    output logic [15:0] o_mar_q,
    output logic        o_mem_ready,
    output logic        o_mem_err,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    input  logic [15:0] i_mem_rdata,
    input  logic        i_mem_ack
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    // state  | meaning
    // S_IDLE | accept MAR/MDR loads and access commands
    // S_REQ  | mem_req held until ack or timeout; commands ignored
    // S_DONE | one-cycle mem_ready, counter cleared
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t        r_state, w_state_next;
    logic [15:0]   r_mar, w_mar_next;
    logic [15:0]   r_mdr, w_mdr_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic          r_we, w_we_next;
    logic          r_err, w_err_next;
    logic          w_start;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_mar   <= '0;
            r_mdr   <= '0;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_mar   <= w_mar_next;
            r_mdr   <= w_mdr_next;
            r_cnt   <= w_cnt_next;
            r_we    <= w_we_next;
            r_err   <= w_err_next;
        end
    end

    // An access never starts in a cycle that also loads MAR, so it sees the new address.
    assign w_start = !i_ldMAR && (i_memWE || (i_ldMDR && i_selMDR));

    always_comb begin
        w_state_next = r_state;
        w_mar_next   = r_mar;
        w_mdr_next   = r_mdr;
        w_cnt_next   = r_cnt;
        w_we_next    = r_we;
        w_err_next   = r_err;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (i_ldMAR)
                    w_mar_next = i_bus_in;
                if (w_start) begin
                    w_we_next    = i_memWE;
                    w_state_next = S_REQ;
                end else if (i_ldMDR && !i_selMDR) begin
                    w_mdr_next = i_bus_in;
                end
            end
            S_REQ: begin
                if (i_mem_ack) begin
                    if (!r_we)
                        w_mdr_next = i_mem_rdata;
                    w_state_next = S_DONE;
                end else if (r_cnt == CW'(TIMEOUT_CYC)) begin
                    w_err_next = 1'b1;
                    if (!r_we)
                        w_mdr_next = 16'h0000;
                    w_state_next = S_DONE;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_DONE: begin
                w_cnt_next   = '0;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign o_mdr_bus   = i_enaMDR ? r_mdr : 16'h0000;
    assign o_mar_q     = r_mar;
    assign o_mem_addr  = r_mar;
    assign o_mem_wdata = r_mdr;
    assign o_mem_req   = (r_state == S_REQ);
    assign o_mem_ready = (r_state == S_DONE);
    assign o_mem_we    = r_we;
    assign o_mem_err   = r_err;

endmodule

// File: tb/tb_lc3_mem_interface.sv
// Directed bench for lc3_mem_interface: fetch, store, timeout, command collisions
// and reset during an access, with a short timeout so the limit is reachable.
module tb_lc3_mem_interface;

    logic        clk = 1'b0;
    logic        reset, ldMAR, ldMDR, selMDR, memWE, enaMDR, mem_ack;
    logic [15:0] bus_in, mem_rdata;
    logic [15:0] mdr_bus, mar_q, mem_addr, mem_wdata;
    logic        mem_ready, mem_err, mem_req, mem_we;
    int          n_cmp = 0;
    int          n_bad = 0;

    lc3_mem_interface #(.TIMEOUT_CYC(4)) dut (
        .i_clk(clk), .i_reset(reset), .i_bus_in(bus_in),
        .i_ldMAR(ldMAR), .i_ldMDR(ldMDR), .i_selMDR(selMDR), .i_memWE(memWE),
        .i_enaMDR(enaMDR), .o_mdr_bus(mdr_bus), .o_mar_q(mar_q),
        .o_mem_ready(mem_ready), .o_mem_err(mem_err), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_req(mem_req), .o_mem_we(mem_we),
        .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ldMAR = 0; ldMDR = 0; selMDR = 0; memWE = 0; enaMDR = 0;
        mem_ack = 0; bus_in = 16'h0; mem_rdata = 16'h0;
        tick(); tick();
        reset = 1'b0;
        n_cmp++; if (mar_q !== 16'h0) begin n_bad++; $display("FAIL reset_mar got %h want 0000", mar_q); end
        n_cmp++; if (mem_wdata !== 16'h0) begin n_bad++; $display("FAIL reset_mdr got %h want 0000", mem_wdata); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got %b want 0", mem_req); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_we got %b want 0", mem_we); end
        n_cmp++; if (mem_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", mem_ready); end
        n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", mem_err); end
        n_cmp++; if (mdr_bus !== 16'h0) begin n_bad++; $display("FAIL reset_mdr_bus got %h want 0000", mdr_bus); end
    endtask

    task automatic test_fetch();
        bus_in = 16'h3000; ldMAR = 1; tick();
        ldMAR = 0; ldMDR = 1; selMDR = 1; tick();
        n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL fetch_req got %b want 1", mem_req); end
        n_cmp++; if (mem_addr !== 16'h3000) begin n_bad++; $display("FAIL fetch_addr got %h want 3000", mem_addr); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL fetch_we got %b want 0", mem_we); end
        mem_ack = 1; mem_rdata = 16'h1261; tick();
        mem_ack = 0; ldMDR = 0; selMDR = 0;
        n_cmp++; if (mem_ready !== 1'b1) begin n_bad++; $display("FAIL fetch_ready got %b want 1", mem_ready); end
        n_cmp++; if (mem_wdata !== 16'h1261) begin n_bad++; $display("FAIL fetch_mdr got %h want 1261", mem_wdata); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL fetch_req_done got %b want 0", mem_req); end
        tick();
        n_cmp++; if (mem_ready !== 1'b0) begin n_bad++; $display("FAIL fetch_ready_pulse got %b want 0", mem_ready); end
        enaMDR = 1; #1;
        n_cmp++; if (mdr_bus !== 16'h1261) begin n_bad++; $display("FAIL fetch_mdr_bus got %h want 1261", mdr_bus); end
        enaMDR = 0;
    endtask

    task automatic test_store();
        bus_in = 16'h4000; ldMAR = 1; tick();
        ldMAR = 0; bus_in = 16'hBEEF; ldMDR = 1; selMDR = 0; tick();
        ldMDR = 0; memWE = 1; tick();
        memWE = 0;
        for (int i = 1; i <= 4; i++) begin
            n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL store_req_cyc%0d got %b want 1", i, mem_req); end
            if (i == 1) begin
                n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL store_we got %b want 1", mem_we); end
                n_cmp++; if (mem_wdata !== 16'hBEEF) begin n_bad++; $display("FAIL store_wdata got %h want beef", mem_wdata); end
            end
            if (i == 4) mem_ack = 1;
            tick();
        end
        mem_ack = 0;
        n_cmp++; if (mem_ready !== 1'b1) begin n_bad++; $display("FAIL store_ready got %b want 1", mem_ready); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL store_req_done got %b want 0", mem_req); end
        n_cmp++; if (mem_wdata !== 16'hBEEF) begin n_bad++; $display("FAIL store_mdr_kept got %h want beef", mem_wdata); end
        tick();
    endtask

    task automatic test_timeout();
        int n;
        bus_in = 16'h7000; ldMAR = 1; tick();
        ldMAR = 0; ldMDR = 1; selMDR = 1; tick();
        ldMDR = 0; selMDR = 0;
        n = 1;
        while (mem_ready !== 1'b1 && n < 20) begin tick(); n++; end
        n_cmp++; if (n !== 6) begin n_bad++; $display("FAIL timeout_latency got %0d want 5", n - 1); end
        n_cmp++; if (mem_wdata !== 16'h0000) begin n_bad++; $display("FAIL timeout_mdr got %h want 0000", mem_wdata); end
        n_cmp++; if (mem_err !== 1'b1) begin n_bad++; $display("FAIL timeout_err got %b want 1", mem_err); end
        tick();
        ldMDR = 1; selMDR = 1; tick();
        ldMDR = 0; selMDR = 0; mem_ack = 1; mem_rdata = 16'hABCD; tick();
        mem_ack = 0;
        n_cmp++; if (mem_ready !== 1'b1) begin n_bad++; $display("FAIL after_to_ready got %b want 1", mem_ready); end
        n_cmp++; if (mem_wdata !== 16'hABCD) begin n_bad++; $display("FAIL after_to_mdr got %h want abcd", mem_wdata); end
        n_cmp++; if (mem_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b want 1", mem_err); end
        tick();
    endtask

    task automatic test_collisions();
        bus_in = 16'h5000; ldMAR = 1; ldMDR = 1; selMDR = 1; tick();
        n_cmp++; if (mar_q !== 16'h5000) begin n_bad++; $display("FAIL coll_mar got %h want 5000", mar_q); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL coll_no_start got %b want 0", mem_req); end
        ldMAR = 0; tick();
        ldMDR = 0; selMDR = 0;
        n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL coll_req got %b want 1", mem_req); end
        n_cmp++; if (mem_addr !== 16'h5000) begin n_bad++; $display("FAIL coll_addr got %h want 5000", mem_addr); end
        bus_in = 16'h6000; ldMAR = 1; tick();
        ldMAR = 0;
        n_cmp++; if (mar_q !== 16'h5000) begin n_bad++; $display("FAIL coll_mar_in_req got %h want 5000", mar_q); end
        mem_ack = 1; mem_rdata = 16'h1111; tick();
        mem_ack = 0;
        n_cmp++; if (mem_ready !== 1'b1) begin n_bad++; $display("FAIL coll_ready got %b want 1", mem_ready); end
        tick();
        ldMDR = 1; selMDR = 1; memWE = 1; tick();
        ldMDR = 0; selMDR = 0; memWE = 0;
        n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL coll_we_wins got %b want 1", mem_we); end
        mem_ack = 1; mem_rdata = 16'h2222; tick();
        mem_ack = 0;
        n_cmp++; if (mem_wdata !== 16'h1111) begin n_bad++; $display("FAIL coll_write_mdr got %h want 1111", mem_wdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        bus_in = 16'h8000; ldMAR = 1; tick();
        ldMAR = 0; ldMDR = 1; selMDR = 1; tick();
        ldMDR = 0; selMDR = 0; tick();
        reset = 1; tick();
        reset = 0;
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rmid_req got %b want 0", mem_req); end
        n_cmp++; if (mar_q !== 16'h0) begin n_bad++; $display("FAIL rmid_mar got %h want 0000", mar_q); end
        n_cmp++; if (mem_wdata !== 16'h0) begin n_bad++; $display("FAIL rmid_mdr got %h want 0000", mem_wdata); end
        n_cmp++; if (mem_ready !== 1'b0) begin n_bad++; $display("FAIL rmid_ready got %b want 0", mem_ready); end
        tick();
        n_cmp++; if (mem_ready !== 1'b0) begin n_bad++; $display("FAIL rmid_ready2 got %b want 0", mem_ready); end
        bus_in = 16'h9000; ldMAR = 1; tick();
        ldMAR = 0; ldMDR = 1; selMDR = 1; tick();
        ldMDR = 0; selMDR = 0; mem_ack = 1; mem_rdata = 16'h3333; tick();
        mem_ack = 0;
        n_cmp++; if (mem_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_fresh_ready got %b want 1", mem_ready); end
        n_cmp++; if (mem_wdata !== 16'h3333) begin n_bad++; $display("FAIL rmid_fresh_mdr got %h want 3333", mem_wdata); end
        n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL rmid_err got %b want 0", mem_err); end
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_timeout();
        test_collisions();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
